fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 32, meaning byte capacity of circular store; SHALL be a power of two and at least 16.
REQ-002 Parameter WORD_BYTES, default 8, meaning bytes delivered per fill beat.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; SHALL clear state immediately on assertion.
REQ-005 fill_valid  input  1  fill beat present.
REQ-006 fill_data  input  64  fill bytes; byte i at fill_data[i*8 +: 8], byte 0 = lowest fetch address.
REQ-007 fill_ready  output  1  buffer can accept a fill beat this cycle.
REQ-008 flush  input  1  discard all buffered bytes (redirect).
REQ-009 byte_incr  input  4  bytes consumed by decoder this cycle, 0..15.
REQ-010 buffer  output  [0:15*8-1]  decode window; byte k at buffer[k*8 +: 8], byte 0 in bits 0..7.
REQ-011 bytes_avail  output  6  valid bytes currently stored, 0..DEPTH.
REQ-012 window_full  output  1  bytes_avail >= 15.
REQ-013 underflow_err  output  1  sticky: a consume exceeded bytes_avail.

Function
REQ-014 State: rd_ptr, wr_ptr (log2 DEPTH bits, modulo wrap), count (0..DEPTH), byte array, underflow_err.
REQ-015 fill_ready SHALL be (count <= DEPTH-WORD_BYTES) and not flush, computed from registered count only.
REQ-016 Fill accepted when fill_valid and fill_ready; all WORD_BYTES bytes written at wr_ptr..wr_ptr+7 with wrap; wr_ptr advances by WORD_BYTES.
REQ-017 Consume legal when byte_incr <= count; rd_ptr advances by byte_incr with wrap; byte_incr = 0 is a no-op.
REQ-018 Illegal consume (byte_incr > count) SHALL be ignored entirely (no pointer/count change) and set underflow_err next cycle.
REQ-019 Simultaneous accepted fill and legal consume: count_next = count + WORD_BYTES - byte_incr; both pointers advance.
REQ-020 Consume SHALL be checked against registered count; bytes filled in the same cycle are not consumable that cycle.
REQ-021 Window: buffer byte k = store[(rd_ptr+k) mod DEPTH] for k < count, else 8'h00; combinational from registered state.
REQ-022 Latency: bytes of an accepted fill appear in buffer and bytes_avail on the following cycle.
REQ-023 bytes_avail = count; window_full = (count >= 15).
REQ-024 flush has priority: next cycle rd_ptr = wr_ptr = 0, count = 0; any same-cycle fill (none accepted, fill_ready low) and consume are discarded; underflow_err unchanged.
REQ-025 Full: count = DEPTH-WORD_BYTES+1..DEPTH holds fill_ready low; consume in that cycle still applies.
REQ-026 Empty: count = 0 yields buffer all zero and window_full low.

Reset
REQ-027 On reset assertion, asynchronously: rd_ptr = 0, wr_ptr = 0, count = 0, underflow_err = 0; outputs fill_ready = 1, bytes_avail = 0, window_full = 0, buffer = 0.
REQ-028 Byte array contents need not be reset; they SHALL never be visible beyond count.
REQ-029 Reset asserted mid-fill or mid-consume SHALL discard the operation; first accepted fill after release lands at store index 0.

Verification
REQ-030 Reset, then fill 0x0706050403020100 and 0x0F0E0D0C0B0A0908 -> next cycle bytes_avail = 16, window_full = 1, buffer bytes 0..14 = 0x00..0x0E.
REQ-031 From REQ-030 state, byte_incr = 3 -> bytes_avail = 13, buffer byte 0 = 0x03, byte 12 = 0x0F, bytes 13..14 = 0x00, window_full = 0.
REQ-032 Fill to count = 25 -> fill_ready = 0; consume 2 -> count 23, fill_ready = 1; fill plus consume 5 same cycle -> count 26.
REQ-033 Wrap: after 40 bytes filled and 30 consumed, window bytes SHALL read addresses 30..39 in order across store index 31->0.
REQ-034 count = 4, byte_incr = 6 -> state unchanged, underflow_err = 1 and stays 1 through a later flush; cleared only by reset.
REQ-035 flush with fill_valid = 1 and byte_incr = 4 same cycle -> fill_ready = 0 that cycle, next cycle bytes_avail = 0, buffer = 0.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch byte buffer: a circular byte store filled one beat at a time,
// which presents a 15-byte decode window starting at the read pointer.
module fetch_buffer #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned WORD_BYTES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_valid,
  input  logic [63:0]       fill_data,
  output logic              fill_ready,
  input  logic              flush,
  input  logic [3:0]        byte_incr,
  output logic [0:15*8-1]   buffer,
  output logic [5:0]        bytes_avail,
  output logic              window_full,
  output logic              underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_err_q, underflow_err_d;
  logic [7:0]       store_q [DEPTH];
  logic [7:0]       store_d [DEPTH];

  logic fill_acc;
  logic consume_ok;

  always_comb begin
    fill_ready = (count_q <= CNT_W'(DEPTH - WORD_BYTES)) && !flush;
    fill_acc   = fill_valid && fill_ready;
    consume_ok = (CNT_W'(byte_incr) <= count_q);
  end

  always_comb begin
    logic [PTR_W-1:0] wr_idx;
    wr_idx          = '0;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    underflow_err_d = underflow_err_q;
    store_d         = store_q;
    if (flush) begin
      // Redirect drops everything but keeps the sticky error.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fill_acc) begin
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
          wr_idx          = wr_ptr_q + PTR_W'(i);
          store_d[wr_idx] = fill_data[i*8 +: 8];
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(WORD_BYTES);
      end
      if (consume_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(byte_incr);
      end else begin
        underflow_err_d = 1'b1;
      end
      count_d = count_q
              + (fill_acc   ? CNT_W'(WORD_BYTES) : '0)
              - (consume_ok ? CNT_W'(byte_incr)  : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  // Store contents are never reset; the window masks anything beyond count.
  always_ff @(posedge clk) begin
    store_q <= store_d;
  end

  always_comb begin
    logic [PTR_W-1:0] rd_idx;
    rd_idx = '0;
    buffer = '0;
    for (int unsigned k = 0; k < 15; k++) begin
      rd_idx = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        buffer[k*8 +: 8] = store_q[rd_idx];
      end
    end
  end

  always_comb begin
    bytes_avail   = 6'(count_q);
    window_full   = (count_q >= CNT_W'(15));
    underflow_err = underflow_err_q;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a vector table for the main fill/consume flow
// plus hand sequences for wrap, underflow, flush and mid-operation reset.
module tb_fetch_buffer;

  logic            clk;
  logic            reset;
  logic            fill_valid;
  logic [63:0]     fill_data;
  logic            fill_ready;
  logic            flush;
  logic [3:0]      byte_incr;
  logic [0:15*8-1] buffer;
  logic [5:0]      bytes_avail;
  logic            window_full;
  logic            underflow_err;

  int total = 0;
  int bad   = 0;

  fetch_buffer #(.DEPTH(32), .WORD_BYTES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .fill_valid   (fill_valid),
    .fill_data    (fill_data),
    .fill_ready   (fill_ready),
    .flush        (flush),
    .byte_incr    (byte_incr),
    .buffer       (buffer),
    .bytes_avail  (bytes_avail),
    .window_full  (window_full),
    .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [63:0] fd;
    logic [3:0]  incr;
    logic        exp_rdy;
    int          exp_avail;
    logic        exp_full;
    logic [7:0]  exp_b0;
    int          ka;
    logic [7:0]  ea;
    int          kb;
    logic [7:0]  eb;
  } vec_t;

  vec_t vecs [10];

  // Beat whose bytes equal their fetch addresses base..base+7.
  function automatic logic [63:0] beat(input int base);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(base + i);
    return r;
  endfunction

  function automatic logic [7:0] gb(input int k);
    return buffer[k*8 +: 8];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [63:0] fd, input logic fl, input logic [3:0] incr);
    fill_valid = fv;
    fill_data  = fd;
    flush      = fl;
    byte_incr  = incr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            fv   data        incr rdy avail full b0     ka  ea     kb  eb
    vecs[0] = '{1'b1, beat(0),  4'd0,  1'b1, 8,  1'b0, 8'h00, 7,  8'h07, 8,  8'h00};
    vecs[1] = '{1'b1, beat(8),  4'd0,  1'b1, 16, 1'b1, 8'h00, 14, 8'h0E, 1,  8'h01};
    vecs[2] = '{1'b0, 64'h0,    4'd3,  1'b1, 13, 1'b0, 8'h03, 12, 8'h0F, 13, 8'h00};
    vecs[3] = '{1'b1, beat(16), 4'd0,  1'b1, 21, 1'b1, 8'h03, 14, 8'h11, 13, 8'h10};
    vecs[4] = '{1'b1, beat(24), 4'd4,  1'b1, 25, 1'b1, 8'h07, 14, 8'h15, 8,  8'h0F};
    vecs[5] = '{1'b0, 64'h0,    4'd0,  1'b0, 25, 1'b1, 8'h07, 14, 8'h15, 1,  8'h08};
    vecs[6] = '{1'b1, beat(32), 4'd2,  1'b0, 23, 1'b1, 8'h09, 14, 8'h17, 13, 8'h16};
    vecs[7] = '{1'b1, beat(32), 4'd5,  1'b1, 26, 1'b1, 8'h0E, 14, 8'h1C, 13, 8'h1B};
    vecs[8] = '{1'b0, 64'h0,    4'd15, 1'b0, 11, 1'b0, 8'h1D, 2,  8'h1F, 3,  8'h20};
    vecs[9] = '{1'b0, 64'h0,    4'd1,  1'b1, 10, 1'b0, 8'h1E, 9,  8'h27, 10, 8'h00};

    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 4'd0);
    #1;
    chk("rst avail", 64'(bytes_avail), 64'd0);
    chk("rst ready", 64'(fill_ready), 64'd1);
    chk("rst full", 64'(window_full), 64'd0);
    chk("rst uerr", 64'(underflow_err), 64'd0);
    chk("rst buf zero", 64'(buffer == '0), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].fv, vecs[i].fd, 1'b0, vecs[i].incr);
      #1;
      chk($sformatf("v%0d ready", i), 64'(fill_ready), 64'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("v%0d avail", i), 64'(bytes_avail), 64'(vecs[i].exp_avail));
      chk($sformatf("v%0d full", i), 64'(window_full), 64'(vecs[i].exp_full));
      chk($sformatf("v%0d uerr", i), 64'(underflow_err), 64'd0);
      chk($sformatf("v%0d b0", i), 64'(gb(0)), 64'(vecs[i].exp_b0));
      chk($sformatf("v%0d b%0d", i, vecs[i].ka), 64'(gb(vecs[i].ka)), 64'(vecs[i].ea));
      chk($sformatf("v%0d b%0d", i, vecs[i].kb), 64'(gb(vecs[i].kb)), 64'(vecs[i].eb));
    end

    // Window now spans addresses 30..39 across store index 31->0.
    for (int k = 0; k < 15; k++)
      chk($sformatf("wrap b%0d", k), 64'(gb(k)), (k < 10) ? 64'(8'h1E + k) : 64'd0);

    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 4'd6);
    tick();
    chk("pre-uf avail", 64'(bytes_avail), 64'd4);
    chk("pre-uf b0", 64'(gb(0)), 64'h24);
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 4'd6);
    tick();
    chk("uf avail", 64'(bytes_avail), 64'd4);
    chk("uf b0", 64'(gb(0)), 64'h24);
    chk("uf uerr", 64'(underflow_err), 64'd1);
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 4'd0);
    tick();
    chk("uf sticky", 64'(underflow_err), 64'd1);

    @(negedge clk);
    drive(1'b1, beat(40), 1'b1, 4'd4);
    #1;
    chk("flush ready", 64'(fill_ready), 64'd0);
    tick();
    chk("flush avail", 64'(bytes_avail), 64'd0);
    chk("flush full", 64'(window_full), 64'd0);
    chk("flush buf zero", 64'(buffer == '0), 64'd1);
    chk("flush uerr", 64'(underflow_err), 64'd1);
    @(negedge clk);
    drive(1'b1, beat(0), 1'b0, 4'd0);
    tick();
    chk("postflush avail", 64'(bytes_avail), 64'd8);
    chk("postflush b0", 64'(gb(0)), 64'h00);
    chk("postflush b7", 64'(gb(7)), 64'h07);

    @(negedge clk);
    drive(1'b1, beat(8), 1'b0, 4'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst avail", 64'(bytes_avail), 64'd0);
    chk("async rst uerr", 64'(underflow_err), 64'd0);
    chk("async rst ready", 64'(fill_ready), 64'd1);
    chk("async rst buf", 64'(buffer == '0), 64'd1);
    tick();
    chk("held rst avail", 64'(bytes_avail), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    byte_incr = 4'd0;
    tick();
    chk("after rst avail", 64'(bytes_avail), 64'd8);
    chk("after rst b0", 64'(gb(0)), 64'h08);
    chk("after rst b7", 64'(gb(7)), 64'h0F);
    chk("after rst b8", 64'(gb(8)), 64'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
